alu_share_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters, e.g. the execute datapath and a debug/CSR helper port.
- Each requester uses a valid/ready request channel. One response channel is shared and carries a requester ID.
- The block registers the operands, drives the ALU for exactly one cycle, captures the result and flags, and holds them until the response is consumed. The ALU instance sits outside the block and connects through the alu_* ports.

---
 rtl/alu_share_arbiter_pkg.sv | 32 +++
 rtl/alu_share_arbiter_if.sv | 46 ++++
 rtl/alu_share_arbiter_rr_grant2.sv | 28 ++
 rtl/alu_share_arbiter.sv | 83 ++++++++
 tb/tb_alu_share_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
// Shared definitions for the ALU sharing arbiter: FSM state encoding,
// the 3-bit ALU control codes and a helper that picks one requester's
// control field out of the packed request bus.
// No ports (package).

package alu_share_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Requester i owns bits [i*3 +: 3] of the packed control bus.
    function automatic logic [2:0] ctrl_slice(input logic [5:0] ctrl, input logic id);
        return id ? ctrl[5:3] : ctrl[2:0];
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
// Bundles the two request channels, the shared response channel, the
// busy flag and the link to the external combinational ALU.
//   slave  : arbiter side (takes requests, produces responses, drives ALU)
//   master : environment side (requesters, response consumer, ALU)
// Parameter WIDTH: datapath width of operands and result.

interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_src_a;
    logic [2*WIDTH-1:0] req_src_b;
    logic [5:0]         req_ctrl;

    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [WIDTH-1:0]   resp_result;
    logic               resp_zero;
    logic               resp_sign;
    logic               busy;

    logic [WIDTH-1:0]   alu_src_a;
    logic [WIDTH-1:0]   alu_src_b;
    logic [2:0]         alu_control;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_zero;
    logic               alu_sign;

    modport slave (
        input  req_valid, req_src_a, req_src_b, req_ctrl, resp_ready,
               alu_result, alu_zero, alu_sign,
        output req_ready, resp_valid, resp_id, resp_result, resp_zero,
               resp_sign, busy, alu_src_a, alu_src_b, alu_control
    );

    modport master (
        output req_valid, req_src_a, req_src_b, req_ctrl, resp_ready,
               alu_result, alu_zero, alu_sign,
        input  req_ready, resp_valid, resp_id, resp_result, resp_zero,
               resp_sign, busy, alu_src_a, alu_src_b, alu_control
    );

endinterface

// File: rtl/alu_share_arbiter_rr_grant2.sv
// rr_grant2
// Combinational two-way round-robin picker.
//   req[1:0]   : request bits
//   last_grant : requester granted most recently
//   gnt_valid  : some requester is granted
//   gnt_id     : index of the granted requester

module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // A lone requester always wins; under contention the one that did
    // not win last time goes next, so neither side can starve.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one external combinational ALU between two valid/ready requesters.
// An accepted operation is latched onto the alu_* outputs, the ALU result
// and flags are captured one cycle later, and the response is held on the
// shared response channel (tagged with the requester id) until consumed.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : alu_share_arbiter_if.slave (requests, response, busy, ALU link)
// Parameter WIDTH: datapath width, must match the interface.

module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus
);

    state_t state;
    logic   last_grant;
    logic   gnt_valid;
    logic   gnt_id;

    rr_grant2 u_rr_grant2 (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Accept only while idle; the ready bit goes to the winner alone.
    assign bus.req_ready  = (state == IDLE && gnt_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_valid = (state == RESP);
    assign bus.busy       = (state != IDLE);

    // Single-process FSM. The alu_* registers keep the last latched
    // operation outside EXEC so the ALU inputs never glitch back to zero;
    // the resp_* registers only change in EXEC, which keeps them stable
    // for the whole time the response waits for resp_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            bus.resp_id     <= 1'b0;
            bus.resp_result <= '0;
            bus.resp_zero   <= 1'b0;
            bus.resp_sign   <= 1'b0;
            bus.alu_src_a   <= '0;
            bus.alu_src_b   <= '0;
            bus.alu_control <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        bus.alu_src_a   <= gnt_id ? bus.req_src_a[2*WIDTH-1:WIDTH]
                                                  : bus.req_src_a[WIDTH-1:0];
                        bus.alu_src_b   <= gnt_id ? bus.req_src_b[2*WIDTH-1:WIDTH]
                                                  : bus.req_src_b[WIDTH-1:0];
                        bus.alu_control <= ctrl_slice(bus.req_ctrl, gnt_id);
                        bus.resp_id     <= gnt_id;
                        last_grant      <= gnt_id;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    bus.resp_result <= bus.alu_result;
                    bus.resp_zero   <= bus.alu_zero;
                    bus.resp_sign   <= bus.alu_sign;
                    state           <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Self-checking bench for alu_share_arbiter: directed scenarios with
// hand-computed results, then randomized traffic compared against a
// transaction-level model (one outstanding operation, response visible two
// cycles after acceptance, round-robin grant under contention).
// The external ALU is modelled here as plain arithmetic.

module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             sign;
        int               visibleAt;
    } txn_t;

    // Behavioural ALU: what each control code means arithmetically.
    function automatic logic [WIDTH-1:0] aluRef(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] c);
        case (c)
            ALU_ADD: return a + b;
            ALU_SHL: return a << b[4:0];
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SHR: return a >> b[4:0];
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            default: return '0;
        endcase
    endfunction

    // External combinational ALU attached to the alu_* ports.
    assign bus.alu_result = aluRef(bus.alu_src_a, bus.alu_src_b, bus.alu_control);
    assign bus.alu_zero   = (bus.alu_result == '0);
    assign bus.alu_sign   = bus.alu_result[WIDTH-1];

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic valid,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] ctrl);
        bus.req_valid[id]                = valid;
        bus.req_src_a[id*WIDTH +: WIDTH] = a;
        bus.req_src_b[id*WIDTH +: WIDTH] = b;
        bus.req_ctrl[id*3 +: 3]          = ctrl;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic doReset();
        reset          = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_src_a  = '0;
        bus.req_src_b  = '0;
        bus.req_ctrl   = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Entered at posedge+1 with requests already driven. Waits (bounded)
    // for the expected grant, follows the operation through to the
    // consumed response and returns at posedge+1.
    task automatic serveOne(input string tag, input logic expId,
                            input logic [WIDTH-1:0] expResult, input logic expZero,
                            input logic expSign, input int holdCycles);
        int waitCycles = 0;
        @(negedge clk);
        while (bus.req_ready == 2'b00 && waitCycles < 10) begin
            @(posedge clk);
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({tag, ".ready"}, {62'd0, bus.req_ready}, expId ? 64'd2 : 64'd1);
        checkOutput({tag, ".idle_busy"}, {63'd0, bus.busy}, 64'd0);
        checkOutput({tag, ".idle_valid"}, {63'd0, bus.resp_valid}, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid[expId] = 1'b0;
        bus.resp_ready       = (holdCycles == 0);
        @(negedge clk);
        checkOutput({tag, ".exec_busy"}, {63'd0, bus.busy}, 64'd1);
        checkOutput({tag, ".exec_valid"}, {63'd0, bus.resp_valid}, 64'd0);
        checkOutput({tag, ".exec_ready"}, {62'd0, bus.req_ready}, 64'd0);
        @(posedge clk);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, ".hold_valid"}, {63'd0, bus.resp_valid}, 64'd1);
            checkOutput({tag, ".hold_result"}, {32'd0, bus.resp_result}, {32'd0, expResult});
            checkOutput({tag, ".hold_sign"}, {63'd0, bus.resp_sign}, {63'd0, expSign});
            checkOutput({tag, ".hold_ready"}, {62'd0, bus.req_ready}, 64'd0);
            checkOutput({tag, ".hold_busy"}, {63'd0, bus.busy}, 64'd1);
            @(posedge clk);
        end
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".valid"}, {63'd0, bus.resp_valid}, 64'd1);
        checkOutput({tag, ".id"}, {63'd0, bus.resp_id}, {63'd0, expId});
        checkOutput({tag, ".result"}, {32'd0, bus.resp_result}, {32'd0, expResult});
        checkOutput({tag, ".zero"}, {63'd0, bus.resp_zero}, {63'd0, expZero});
        checkOutput({tag, ".sign"}, {63'd0, bus.resp_sign}, {63'd0, expSign});
        @(posedge clk);
        #1;
    endtask

    // Randomized traffic against the transaction-level model.
    task automatic runRandom(input int cycles);
        txn_t             pending[$];
        txn_t             t;
        logic             modelLast = 1'b1;
        logic [1:0]       accepted  = 2'b00;
        logic [1:0]       expReady;
        logic             expBusy;
        logic             expValid;
        logic             g;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (accepted[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        a = $urandom;
                        b = ($urandom_range(5) == 0) ? a : $urandom;
                        applyStimulus(i, 1'b1, a, b, 3'($urandom_range(7)));
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(9) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            accepted       = 2'b00;
            bus.resp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            expBusy  = (pending.size() != 0);
            expValid = expBusy && (cyc >= pending[0].visibleAt);
            expReady = 2'b00;
            g        = 1'b0;
            if (!expBusy && bus.req_valid != 2'b00) begin
                if (bus.req_valid == 2'b11) g = ~modelLast;
                else                        g = bus.req_valid[1];
                expReady = g ? 2'b10 : 2'b01;
            end
            checkOutput("rnd.req_ready", {62'd0, bus.req_ready}, {62'd0, expReady});
            checkOutput("rnd.busy", {63'd0, bus.busy}, {63'd0, expBusy});
            checkOutput("rnd.resp_valid", {63'd0, bus.resp_valid}, {63'd0, expValid});
            if (expValid) begin
                checkOutput("rnd.resp_id", {63'd0, bus.resp_id}, {63'd0, pending[0].id});
                checkOutput("rnd.resp_result", {32'd0, bus.resp_result}, {32'd0, pending[0].result});
                checkOutput("rnd.resp_zero", {63'd0, bus.resp_zero}, {63'd0, pending[0].zero});
                checkOutput("rnd.resp_sign", {63'd0, bus.resp_sign}, {63'd0, pending[0].sign});
            end
            if (expReady != 2'b00) begin
                r           = aluRef(bus.req_src_a[g*WIDTH +: WIDTH],
                                     bus.req_src_b[g*WIDTH +: WIDTH],
                                     bus.req_ctrl[g*3 +: 3]);
                t.id        = g;
                t.result    = r;
                t.zero      = (r == '0);
                t.sign      = r[WIDTH-1];
                t.visibleAt = cyc + 2;
                pending.push_back(t);
                modelLast   = g;
                accepted[g] = 1'b1;
            end else if (expValid && bus.resp_ready) begin
                void'(pending.pop_front());
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        doReset();

        // Reset state
        @(negedge clk);
        checkOutput("rst.resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        checkOutput("rst.busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("rst.resp_id", {63'd0, bus.resp_id}, 64'd0);
        checkOutput("rst.resp_result", {32'd0, bus.resp_result}, 64'd0);
        checkOutput("rst.alu_src_a", {32'd0, bus.alu_src_a}, 64'd0);
        checkOutput("rst.alu_src_b", {32'd0, bus.alu_src_b}, 64'd0);
        checkOutput("rst.alu_control", {61'd0, bus.alu_control}, 64'd0);
        checkOutput("rst.req_ready", {62'd0, bus.req_ready}, 64'd0);
        @(posedge clk);
        #1;

        // Single request: 5 + 3
        applyStimulus(0, 1'b1, 32'd5, 32'd3, ALU_ADD);
        serveOne("add", 1'b0, 32'd8, 1'b0, 1'b0, 0);

        // Contention straight after reset: r0 first, then r1
        doReset();
        applyStimulus(0, 1'b1, 32'd7, 32'd7, ALU_SUB);
        applyStimulus(1, 1'b1, 32'hF0, 32'h0F, ALU_OR);
        serveOne("cont0", 1'b0, 32'd0, 1'b1, 1'b0, 0);
        serveOne("cont1", 1'b1, 32'hFF, 1'b0, 1'b0, 0);

        // Second contention: fairness hands it back to r0
        applyStimulus(0, 1'b1, 32'hAA, 32'h0F, ALU_AND);
        applyStimulus(1, 1'b1, 32'h0F, 32'hFF, ALU_XOR);
        serveOne("cont2", 1'b0, 32'h0A, 1'b0, 1'b0, 0);
        serveOne("cont3", 1'b1, 32'hF0, 1'b0, 1'b0, 0);

        // Backpressure: 0 - 1 held for 5 cycles
        applyStimulus(1, 1'b1, 32'd0, 32'd1, ALU_SUB);
        serveOne("bp", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 5);
        @(negedge clk);
        checkOutput("bp.release_valid", {63'd0, bus.resp_valid}, 64'd0);
        checkOutput("bp.release_busy", {63'd0, bus.busy}, 64'd0);
        @(posedge clk);
        #1;

        // Reset while in EXEC (r0 was last granted, so reset must restore r0 priority)
        applyStimulus(0, 1'b1, 32'h11, 32'h22, ALU_XOR);
        @(negedge clk);
        checkOutput("mid.ready", {62'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        @(negedge clk);
        checkOutput("mid.exec_busy", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("mid.resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        checkOutput("mid.busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("mid.alu_src_a", {32'd0, bus.alu_src_a}, 64'd0);
        checkOutput("mid.alu_control", {61'd0, bus.alu_control}, 64'd0);
        checkOutput("mid.resp_result", {32'd0, bus.resp_result}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, 32'd9, 32'd4, ALU_SUB);
        applyStimulus(1, 1'b1, 32'd2, 32'd2, ALU_ADD);
        serveOne("mid.r0", 1'b0, 32'd5, 1'b0, 1'b0, 0);
        serveOne("mid.r1", 1'b1, 32'd4, 1'b0, 1'b0, 0);

        // Shift into the sign bit, then an undefined control code
        applyStimulus(0, 1'b1, 32'd1, 32'd31, ALU_SHL);
        serveOne("shl", 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        applyStimulus(1, 1'b1, 32'h1234, 32'h5678, 3'b011);
        serveOne("undef", 1'b1, 32'd0, 1'b1, 1'b0, 0);

        // Randomized traffic
        doReset();
        runRandom(600);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
